// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-subset core: shared ALU, single req/ready memory port and a
// control FSM that spends 3-5 states per instruction (plus memory wait states).
module multicycle_datapath #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc_out,
  output logic        halted,
  output logic [3:0]  state_out
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_ADDIEX = 4'd8,
    S_ADDIWB = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] alu_out_q, alu_out_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] regs_q [32];

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        req_c;
  logic        we_c;

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [31:0] imm_sext;
  logic        funct_ok;
  logic [31:0] rtype_result;
  state_t      illegal_next;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign illegal_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;

  always_comb begin
    funct_ok     = 1'b1;
    rtype_result = a_q + b_q;
    case (funct)
      FN_ADD:  rtype_result = a_q + b_q;
      FN_SUB:  rtype_result = a_q - b_q;
      FN_AND:  rtype_result = a_q & b_q;
      FN_OR:   rtype_result = a_q | b_q;
      FN_SLT:  rtype_result = {31'd0, $signed(a_q) < $signed(b_q)};
      default: funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_out_d = alu_out_q;
    mdr_d     = mdr_q;
    rf_we     = 1'b0;
    rf_waddr  = rt;
    rf_wdata  = mdr_q;
    req_c     = 1'b0;
    we_c      = 1'b0;
    mem_addr  = alu_out_q;
    case (state_q)
      S_FETCH: begin
        req_c    = 1'b1;
        mem_addr = pc_q;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d       = regs_q[rs];
        b_d       = regs_q[rt];
        // Branch target computed speculatively; pc_q already points past this instruction.
        alu_out_d = pc_q + (imm_sext << 2);
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = funct_ok ? S_EXEC : illegal_next;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = illegal_next;
        endcase
      end
      S_MEMADR: begin
        alu_out_d = a_q + imm_sext;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        req_c = 1'b1;
        if (mem_ready) begin
          mdr_d   = mem_rdata;
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        rf_we    = 1'b1;
        rf_waddr = rt;
        rf_wdata = mdr_q;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        req_c = 1'b1;
        we_c  = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_out_d = rtype_result;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
        rf_wdata = alu_out_q;
        state_d  = S_FETCH;
      end
      S_ADDIEX: begin
        alu_out_d = a_q + imm_sext;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        rf_we    = 1'b1;
        rf_waddr = rt;
        rf_wdata = alu_out_q;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        if (a_q == b_q) pc_d = alu_out_q;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= 32'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      alu_out_q <= 32'd0;
      mdr_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      mdr_q     <= mdr_d;
    end
  end

  // $0 is never written, so it reads back as zero without a read-side mux.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      regs_q[rf_waddr] <= rf_wdata;
    end
  end

  // Request is masked during reset so a held reset never starts a transaction.
  assign mem_req   = req_c & ~reset;
  assign mem_we    = we_c & ~reset;
  assign mem_wdata = b_q;
  assign pc_out    = pc_q;
  assign halted    = (state_q == S_HALT);
  assign state_out = state_q;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench: one core halts on illegal opcodes (RESET_PC=0x100), a second treats them as NOPs.
module tb_multicycle_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
  logic        halted;
  logic [3:0]  state_out;

  logic        mem_req2, mem_we2, mem_ready2;
  logic [31:0] mem_addr2, mem_wdata2, mem_rdata2, pc2;
  logic        halted2;
  logic [3:0]  state2;

  logic [31:0] mem  [256];
  logic [31:0] mem2 [16];
  int          wait_n = 0;
  int          cnt = 0;
  logic        force_rdy = 1'b0;
  logic        prev_wait = 1'b0;
  logic        prev_we = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  logic [31:0] prev_wdata = 32'd0;
  logic        unstable = 1'b0;
  int          wr_cnt = 0;
  logic [31:0] wr_addr = 32'd0;
  logic [31:0] wr_data = 32'd0;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  multicycle_datapath #(.RESET_PC(32'h0000_0100), .HALT_ON_ILLEGAL(1'b1)) u_dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc_out(pc_out), .halted(halted), .state_out(state_out)
  );

  multicycle_datapath #(.RESET_PC(32'h0000_0000), .HALT_ON_ILLEGAL(1'b0)) u_nop (
    .clk(clk), .reset(reset),
    .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_rdata(mem_rdata2), .mem_ready(mem_ready2),
    .pc_out(pc2), .halted(halted2), .state_out(state2)
  );

  // Memory with a programmable number of wait cycles on every access.
  assign mem_ready = force_rdy | (mem_req && (cnt == wait_n));
  assign mem_rdata = mem[mem_addr[9:2]];
  assign mem_ready2 = mem_req2;
  assign mem_rdata2 = mem2[mem_addr2[5:2]];

  always @(posedge clk) begin
    if (mem_req && !mem_ready) cnt <= cnt + 1;
    else cnt <= 0;
    if (prev_wait && mem_req &&
        (mem_addr !== prev_addr || mem_we !== prev_we || mem_wdata !== prev_wdata))
      unstable <= 1'b1;
    prev_wait  <= mem_req && !mem_ready;
    prev_addr  <= mem_addr;
    prev_we    <= mem_we;
    prev_wdata <= mem_wdata;
    if (mem_req && mem_ready) begin
      if (mem_we) begin
        mem[mem_addr[9:2]] <= mem_wdata;
        wr_cnt  <= wr_cnt + 1;
        wr_addr <= mem_addr;
        wr_data <= mem_wdata;
        $display("mem wr addr=0x%08h data=0x%08h", mem_addr, mem_wdata);
      end else begin
        $display("mem rd addr=0x%08h data=0x%08h", mem_addr, mem_rdata);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic found;
    reset = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    for (int i = 0; i < 16; i++) mem2[i] = 32'd0;
    mem[32'h100 >> 2] = 32'h2007_0001;  // addi $7,$0,1
    mem[32'h104 >> 2] = 32'h8C07_0080;  // lw   $7,0x80($0)
    mem2[0] = 32'hFC00_0000;            // illegal opcode 0x3F
    mem2[1] = 32'h2001_0009;            // addi $1,$0,9
    wait_n = 10;
    cycles(2);
    reset = 1'b0;

    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      cycles(1);
      if (state_out == 4'd3) found = 1'b1;
    end
    check_eq("reach_memrd", {31'd0, found}, 32'd1);
    check_eq("r7_before_rst", u_dut.regs_q[7], 32'd1);
    cycles(2);

    // Asynchronous reset in the middle of a stalled load, with a stray ready.
    reset = 1'b1;
    force_rdy = 1'b1;
    #1;
    check_eq("rst_state", {28'd0, state_out}, 32'd0);
    check_eq("rst_pc", pc_out, 32'h100);
    check_eq("rst_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_halted", {31'd0, halted}, 32'd0);
    check_eq("rst_r7", u_dut.regs_q[7], 32'd0);
    cycles(2);
    check_eq("rst_hold_state", {28'd0, state_out}, 32'd0);
    check_eq("rst_hold_pc", pc_out, 32'h100);

    mem[32'h100 >> 2] = 32'h2001_0005;  // addi $1,$0,5
    mem[32'h104 >> 2] = 32'h2002_FFFD;  // addi $2,$0,-3
    mem[32'h108 >> 2] = 32'h0022_1820;  // add  $3,$1,$2
    mem[32'h10C >> 2] = 32'h0041_202A;  // slt  $4,$2,$1
    mem[32'h110 >> 2] = 32'hAC03_0008;  // sw   $3,8($0)
    mem[32'h114 >> 2] = 32'h8C05_0008;  // lw   $5,8($0)
    mem[32'h118 >> 2] = 32'h1022_0005;  // beq  $1,$2,+5 (not taken)
    mem[32'h11C >> 2] = 32'h2000_0007;  // addi $0,$0,7
    mem[32'h120 >> 2] = 32'h0020_3020;  // add  $6,$1,$0
    mem[32'h124 >> 2] = 32'h0800_0050;  // j    0x50 -> 0x140
    mem[32'h140 >> 2] = 32'h1021_FFFF;  // beq  $1,$1,-1
    wait_n = 0;
    force_rdy = 1'b0;
    reset = 1'b0;
    #1;
    check_eq("first_req", {31'd0, mem_req}, 32'd1);
    check_eq("first_addr", mem_addr, 32'h100);
    check_eq("first_state", {28'd0, state_out}, 32'd0);
    check_eq("nop_first_addr", mem_addr2, 32'h0);

    cycles(2);
    check_eq("nop_state", {28'd0, state2}, 32'd0);
    check_eq("nop_next_fetch", mem_addr2, 32'h4);
    check_eq("nop_halted", {31'd0, halted2}, 32'd0);
    cycles(4);
    check_eq("nop_r1", u_nop.regs_q[1], 32'd9);
    check_eq("nop_pc", pc2, 32'h8);

    cycles(10);
    check_eq("alu_pc", pc_out, 32'h110);
    check_eq("alu_state", {28'd0, state_out}, 32'd0);
    check_eq("r1", u_dut.regs_q[1], 32'd5);
    check_eq("r2", u_dut.regs_q[2], 32'hFFFF_FFFD);
    check_eq("add_r3", u_dut.regs_q[3], 32'd2);
    check_eq("slt_r4", u_dut.regs_q[4], 32'd1);

    wait_n = 3;
    cycles(10);
    check_eq("sw_pc", pc_out, 32'h114);
    check_eq("sw_state", {28'd0, state_out}, 32'd0);
    check_eq("sw_count", wr_cnt, 32'd1);
    check_eq("sw_addr", wr_addr, 32'h8);
    check_eq("sw_data", wr_data, 32'd2);
    cycles(11);
    check_eq("lw_pc", pc_out, 32'h118);
    check_eq("lw_state", {28'd0, state_out}, 32'd0);
    check_eq("lw_r5", u_dut.regs_q[5], 32'd2);
    check_eq("wait_stable", {31'd0, unstable}, 32'd0);

    wait_n = 0;
    cycles(3);
    check_eq("beq_nt_pc", pc_out, 32'h11C);
    cycles(4);
    check_eq("r0_zero", u_dut.regs_q[0], 32'd0);
    cycles(4);
    check_eq("add_r6", u_dut.regs_q[6], 32'd5);
    cycles(3);
    check_eq("j_pc", pc_out, 32'h140);
    cycles(3);
    check_eq("loop_pc1", pc_out, 32'h140);
    check_eq("loop_state", {28'd0, state_out}, 32'd0);
    cycles(3);
    check_eq("loop_pc2", pc_out, 32'h140);

    mem[32'h140 >> 2] = 32'hFC00_0000;
    cycles(2);
    check_eq("halt_flag", {31'd0, halted}, 32'd1);
    check_eq("halt_state", {28'd0, state_out}, 32'd12);
    check_eq("halt_req", {31'd0, mem_req}, 32'd0);
    check_eq("halt_pc", pc_out, 32'h144);
    force_rdy = 1'b1;
    cycles(10);
    check_eq("halt_stay", {31'd0, halted}, 32'd1);
    check_eq("halt_req_stay", {31'd0, mem_req}, 32'd0);
    check_eq("halt_pc_stay", pc_out, 32'h144);
    force_rdy = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
